snn_event_layer: RTL and testbench

- Parametrised, event-driven leaky integrate-and-fire layer of N_NEURONS neurons fed by N_INPUTS input channels.
- Each accepted input event scans one weight row, one neuron per cycle:
  - adds the weight into that neuron's membrane potential with saturation;
  - on threshold crossing, resets the potential and queues the neuron index in an internal output FIFO.
- Successor to the fixed 16-neuron core: generalised widths and sizes, synchronous reset, configurable threshold, overflow reporting, optional leak.

---
 rtl/snn_event_layer.sv | 148 ++++++++++++++
 tb/tb_snn_event_layer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/snn_event_layer.sv
// Event-driven leaky integrate-and-fire layer: each input event scans one weight row into the
// neuron potentials and queues spiking neuron indices in an output FIFO. Define SNN_LEAK_EN for leak.
//
// state | meaning
// IDLE  | waiting for an input event, in_ready high
// SCAN  | issuing one weight read per neuron, j = 0 .. N_NEURONS-1
// FLUSH | completing the update of the last neuron
module snn_event_layer #(
  parameter int N_NEURONS  = 16,
  parameter int N_INPUTS   = 16,
  parameter int WEIGHT_W   = 8,
  parameter int POT_W      = 12,
  parameter int OUT_DEPTH  = 8,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [$clog2(N_INPUTS)-1:0]            in_addr,
  input  logic                                   cfg_w_en,
  input  logic [$clog2(N_INPUTS*N_NEURONS)-1:0]  cfg_addr,
  input  logic signed [WEIGHT_W-1:0]             cfg_data,
  input  logic signed [POT_W-1:0]                threshold,
  input  logic                                   out_ren,
  output logic [$clog2(N_NEURONS)-1:0]           out_addr,
  output logic                                   out_empty,
  output logic                                   out_overflow,
  output logic                                   busy
);
  localparam int NW = $clog2(N_NEURONS);
  localparam int IW = $clog2(N_INPUTS);
  localparam int AW = $clog2(N_INPUTS*N_NEURONS);
  localparam int FW = $clog2(OUT_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]                 state;
  logic [IW-1:0]              row_q;
  logic signed [POT_W-1:0]    thr_q;
  logic [NW-1:0]              j;
  logic                       upd_valid;
  logic [NW-1:0]              upd_idx;
  logic signed [WEIGHT_W-1:0] w_rd;
  logic [AW-1:0]              rd_addr;

  logic signed [WEIGHT_W-1:0] wmem [N_INPUTS*N_NEURONS];
  logic signed [POT_W-1:0]    pot [N_NEURONS];

  logic signed [POT_W-1:0]    p_cur, p_lk, p_new;
  logic signed [POT_W:0]      sum;
  logic                       fire;

  logic [NW-1:0]              fifo [OUT_DEPTH];
  logic [FW-1:0]              wr_ptr, rd_ptr;
  logic [FW:0]                count;
  logic                       full, pop, push;

  assign rd_addr  = {row_q, j};
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Weight store is never cleared; a same-address write returns the old word to the reader.
  always_ff @(posedge clock) begin
    if (cfg_w_en) wmem[cfg_addr] <= cfg_data;
    if (state == SCAN) w_rd <= wmem[rd_addr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      row_q     <= '0;
      thr_q     <= '0;
      j         <= '0;
      upd_valid <= 1'b0;
      upd_idx   <= '0;
    end else begin
      upd_valid <= (state == SCAN);
      upd_idx   <= j;
      case (state)
        IDLE: if (in_valid) begin
          row_q <= in_addr;
          thr_q <= threshold;
          j     <= '0;
          state <= SCAN;
        end
        SCAN: begin
          j <= j + 1'b1;
          if (&j) state <= FLUSH;
        end
        FLUSH:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    p_cur = pot[upd_idx];
`ifdef SNN_LEAK_EN
    p_lk = p_cur - (p_cur >>> LEAK_SHIFT);
`else
    p_lk = p_cur;
`endif
    sum = {p_lk[POT_W-1], p_lk} + {{(POT_W+1-WEIGHT_W){w_rd[WEIGHT_W-1]}}, w_rd};
    // Top two bits disagree only on overflow; clamp toward the sign of the true result.
    if (sum[POT_W] != sum[POT_W-1])
      p_new = sum[POT_W] ? {1'b1, {(POT_W-1){1'b0}}} : {1'b0, {(POT_W-1){1'b1}}};
    else
      p_new = sum[POT_W-1:0];
  end

  assign fire = upd_valid && (p_new >= thr_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) pot[i] <= '0;
    end else if (upd_valid) begin
      pot[upd_idx] <= fire ? '0 : p_new;
    end
  end

  assign out_empty = (count == '0);
  assign full      = (count == (FW+1)'(OUT_DEPTH));
  assign pop       = out_ren && !out_empty;
  assign push      = fire && (!full || pop);
  assign out_addr  = out_empty ? '0 : fifo[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) fifo[wr_ptr] <= upd_idx;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      out_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      if (fire && !push) out_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_snn_event_layer.sv
// Directed self-checking bench for snn_event_layer (default parameters).
// The leak check is compiled only when SNN_LEAK_EN is defined.
module tb_snn_event_layer;
  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_addr;
  logic              cfg_w_en;
  logic [7:0]        cfg_addr;
  logic signed [7:0] cfg_data;
  logic signed [11:0] threshold;
  logic              out_ren;
  logic [3:0]        out_addr;
  logic              out_empty;
  logic              out_overflow;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  snn_event_layer dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .cfg_w_en(cfg_w_en), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .threshold(threshold), .out_ren(out_ren), .out_addr(out_addr), .out_empty(out_empty),
    .out_overflow(out_overflow), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wr_w(input int ch, input int n, input int data);
    cfg_addr = 8'(ch * 16 + n);
    cfg_data = 8'(data);
    cfg_w_en = 1'b1;
    tick();
    cfg_w_en = 1'b0;
  endtask

  task automatic fill(input int ch, input int data);
    for (int n = 0; n < 16; n++) wr_w(ch, n, data);
  endtask

  task automatic send(input int ch, input int thr, output int busy_cyc);
    int w;
    in_addr   = 4'(ch);
    threshold = 12'(thr);
    in_valid  = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin tick(); w++; end
    if (!in_ready) chk("send_ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    busy_cyc = 0;
    while (busy && busy_cyc < 100) begin tick(); busy_cyc++; end
  endtask

  task automatic pop();
    out_ren = 1'b1;
    tick();
    out_ren = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_addr = '0; cfg_w_en = 1'b0;
    cfg_addr = '0; cfg_data = '0; threshold = '0; out_ren = 1'b0;
    tick(); tick();
    reset = 1'b0;

    chk("rst_empty", int'(out_empty), 1);
    chk("rst_addr", int'(out_addr), 0);
    chk("rst_ovf", int'(out_overflow), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(in_ready), 1);

    for (int ch = 0; ch < 16; ch++) fill(ch, 0);

    // Two sub-threshold accumulations on n5, second one fires.
    wr_w(1, 5, 60);
    send(1, 100, cyc);
    chk("t1_busy1", cyc, 17);
    chk("t1_empty1", int'(out_empty), 1);
    chk("t1_pot5a", int'(dut.pot[5]), 60);
    send(1, 100, cyc);
    chk("t1_busy2", cyc, 17);
    chk("t1_empty2", int'(out_empty), 0);
    chk("t1_addr", int'(out_addr), 5);
    chk("t1_pot5b", int'(dut.pot[5]), 0);
    pop();
    chk("t1_empty3", int'(out_empty), 1);
    out_ren = 1'b1; tick(); out_ren = 1'b0;
    chk("t1_pop_empty", int'(out_empty), 1);

    // Saturation: 16*127=2032, 17th event clamps to 2047 and fires.
    do_reset();
    fill(2, 127);
    for (int k = 0; k < 16; k++) send(2, 2047, cyc);
    chk("t2_pot0_2032", int'(dut.pot[0]), 2032);
    chk("t2_empty16", int'(out_empty), 1);
    send(2, 2047, cyc);
    chk("t2_empty17", int'(out_empty), 0);
    chk("t2_addr17", int'(out_addr), 0);
    chk("t2_pot0_0", int'(dut.pot[0]), 0);
    chk("t2_pot15_0", int'(dut.pot[15]), 0);
    chk("t2_ovf", int'(out_overflow), 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_drain%0d", i), int'(out_addr), i);
      pop();
    end
    chk("t2_drained", int'(out_empty), 1);
    for (int k = 0; k < 3; k++) send(2, 2047, cyc);
    chk("t2_pot7_381", int'(dut.pot[7]), 381);
    chk("t2_empty20", int'(out_empty), 1);

    // FIFO overflow: all 16 neurons fire, only 0..7 retained.
    do_reset();
    fill(3, 120);
    send(3, 100, cyc);
    chk("t3_ovf", int'(out_overflow), 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_q%0d", i), int'(out_addr), i);
      pop();
    end
    chk("t3_empty", int'(out_empty), 1);
    chk("t3_pot12", int'(dut.pot[12]), 0);

    // Negative weight, zero threshold.
    do_reset();
    fill(4, -1);
    wr_w(4, 0, -50);
    send(4, 0, cyc);
    chk("t4_empty1", int'(out_empty), 1);
    chk("t4_pot0", int'(dut.pot[0]), -50);
    chk("t4_pot3", int'(dut.pot[3]), -1);
    fill(5, 0);
    wr_w(5, 0, 50);
    send(5, 0, cyc);
    chk("t4_empty2", int'(out_empty), 0);
    chk("t4_addr", int'(out_addr), 0);
    chk("t4_pot0b", int'(dut.pot[0]), 0);
    pop();
    chk("t4_empty3", int'(out_empty), 1);

    // Reset mid-scan at j=6.
    do_reset();
    in_addr = 4'd3; threshold = 12'sd100; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("t5_j", int'(dut.j), 6);
    chk("t5_pushed", int'(out_empty), 0);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t5_busy", int'(busy), 0);
    chk("t5_ready", int'(in_ready), 1);
    chk("t5_empty", int'(out_empty), 1);
    for (int i = 0; i < 20; i++) tick();
    chk("t5_empty_late", int'(out_empty), 1);
    chk("t5_pot10", int'(dut.pot[10]), 0);
    chk("t5_ovf", int'(out_overflow), 0);

`ifdef SNN_LEAK_EN
    do_reset();
    fill(6, 0);
    wr_w(6, 0, 80);
    send(6, 2047, cyc);
    chk("t6_pot80", int'(dut.pot[0]), 80);
    fill(7, 0);
    send(7, 2047, cyc);
    chk("t6_leak70", int'(dut.pot[0]), 70);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
